// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers, supports slave wait states, aborts a stalled ACCESS after TIMEOUT
// cycles and returns a one-cycle response pulse per transfer.
module apb_master_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [2:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last wait-counter value before an ACCESS that still sees PREADY=0 is aborted
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    logic [7:0] wait_cnt_r;
    logic       accept_s;

    // A new command can be taken while idle, or in the very cycle the current ACCESS completes
    assign cmd_ready = (state_r == IDLE) || ((state_r == ACCESS) && PREADY);
    assign accept_s  = cmd_valid && cmd_ready;

    // Transfer sequencer: state, APB drive, wait counter and response registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 8'd0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 3'd0;
            PWDATA      <= 8'd0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= SETUP;
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    state_r    <= ACCESS;
                    PENABLE    <= 1'b1;
                    wait_cnt_r <= 8'd0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        // Normal completion wins even when the counter is at its limit
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? 8'd0 : PRDATA;
                        if (accept_s) begin
                            state_r <= SETUP;
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Slave stalled too long: abandon the transfer and report it
                        state_r     <= IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        busy        <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 8'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with a small APB slave model.
module tb_apb_master_bridge;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'hFF;
    logic       PREADY = 1'b1;
    logic       PSLVERR = 1'b1;
    logic       busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    apb_master_bridge #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_psel"},    32'(PSEL),        32'd0);
        check_eq({tag, "_penable"}, 32'(PENABLE),     32'd0);
        check_eq({tag, "_pwrite"},  32'(PWRITE),      32'd0);
        check_eq({tag, "_paddr"},   32'(PADDR),       32'd0);
        check_eq({tag, "_pwdata"},  32'(PWDATA),      32'd0);
        check_eq({tag, "_busy"},    32'(busy),        32'd0);
        check_eq({tag, "_rvalid"},  32'(rsp_valid),   32'd0);
        check_eq({tag, "_rdata"},   32'(rsp_rdata),   32'd0);
        check_eq({tag, "_rerr"},    32'(rsp_err),     32'd0);
        check_eq({tag, "_rto"},     32'(rsp_timeout), 32'd0);
    endtask

    // One transfer; the slave raises PREADY in ACCESS cycle number wait_n+1.
    // Outside ACCESS the slave drives garbage that the bridge must ignore.
    task automatic do_xfer(input string tag, input logic wr, input logic [2:0] addr,
                           input logic [7:0] wd, input int wait_n, input logic [7:0] rd,
                           input logic err, input int exp_psel, input int exp_pen,
                           input logic [7:0] exp_rdata, input logic exp_err, input logic exp_to);
        int acc = 0;
        int psel_n = 0;
        int pen_n = 0;
        logic got = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        for (int g = 0; g < 60 && !got; g++) begin
            @(posedge PCLK); #1;
            if (rsp_valid) begin
                got = 1'b1;
                check_eq({tag, "_rdata"},   32'(rsp_rdata),   32'(exp_rdata));
                check_eq({tag, "_rerr"},    32'(rsp_err),     32'(exp_err));
                check_eq({tag, "_rto"},     32'(rsp_timeout), 32'(exp_to));
                check_eq({tag, "_busy_end"}, 32'(busy),       32'd0);
            end
            if (PSEL) begin
                psel_n++;
                check_eq({tag, "_bus"}, {20'd0, PWRITE, PADDR, PWDATA}, {20'd0, wr, addr, wd});
                if (!PENABLE) begin
                    check_eq({tag, "_setup_rdy"}, 32'(cmd_ready), 32'd0);
                    cmd_valid = 1'b0;
                end
            end
            if (PSEL && PENABLE) begin
                acc++; pen_n++;
                PREADY = (acc == wait_n + 1); PRDATA = rd; PSLVERR = err;
            end else begin
                PREADY = 1'b1; PRDATA = 8'hFF; PSLVERR = 1'b1;
            end
        end
        check_eq({tag, "_done"},    32'(got),    32'd1);
        check_eq({tag, "_psel_n"},  32'(psel_n), 32'(exp_psel));
        check_eq({tag, "_pen_n"},   32'(pen_n),  32'(exp_pen));
    endtask

    initial begin
        logic [6:0] psel_bits;
        logic [6:0] pen_bits;
        int pulses;
        int issued;
        int stray;

        // Reset state
        #3;
        check_idle_outputs("reset");
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // Write 0 <- 5A, no wait: PSEL 2 cycles, PENABLE 1 (first edge after reset release)
        do_xfer("wr0", 1'b1, 3'd0, 8'h5A, 0, 8'h00, 1'b0, 2, 1, 8'h00, 1'b0, 1'b0);

        // Read 5 with 3 wait states: ACCESS lasts 4 cycles
        do_xfer("rd5", 1'b0, 3'd5, 8'h00, 3, 8'hC3, 1'b0, 5, 4, 8'hC3, 1'b0, 1'b0);
        @(posedge PCLK); #1;
        check_eq("rd5_hold_rdata", 32'(rsp_rdata), 32'hC3);
        check_eq("rd5_pulse_once", 32'(rsp_valid), 32'd0);

        // Write with slave error
        do_xfer("wrerr", 1'b1, 3'd2, 8'hA5, 1, 8'h77, 1'b1, 3, 2, 8'h00, 1'b1, 1'b0);

        // Read held off forever: abort after 16 ACCESS cycles
        do_xfer("tmo", 1'b0, 3'd6, 8'h00, 1000, 8'h99, 1'b0, 17, 16, 8'h00, 1'b1, 1'b1);

        // Slave ready on the last allowed cycle counts as normal completion
        do_xfer("edge", 1'b0, 3'd4, 8'h00, 15, 8'h3E, 1'b0, 17, 16, 8'h3E, 1'b0, 1'b0);

        // Three back-to-back reads, cmd_valid held, zero waits
        psel_bits = '0; pen_bits = '0; pulses = 0; issued = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1; cmd_wdata = 8'd0;
        for (int c = 0; c < 9; c++) begin
            @(posedge PCLK); #1;
            if (c < 7) begin
                psel_bits[c] = PSEL;
                pen_bits[c]  = PENABLE;
            end
            if (rsp_valid) begin
                pulses++;
                check_eq("b2b_rdata", 32'(rsp_rdata), 32'(8'h10 + 8'(pulses)));
            end
            if (PSEL && !PENABLE) begin
                issued++;
                if (issued == 3) cmd_valid = 1'b0;
                else cmd_addr = 3'(issued + 1);
            end
            PREADY = PSEL && PENABLE;
            PRDATA = 8'h10 + {5'd0, PADDR};
            PSLVERR = 1'b0;
        end
        check_eq("b2b_psel",   32'(psel_bits), 32'(7'b0111111));
        check_eq("b2b_pen",    32'(pen_bits),  32'(7'b0101010));
        check_eq("b2b_pulses", 32'(pulses),    32'd3);

        // Reset in the middle of an ACCESS wait
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd7; cmd_wdata = 8'h3C;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; PREADY = 1'b0;
        @(posedge PCLK); #1;
        check_eq("rst_mid_in_access", 32'({PSEL, PENABLE}), 32'd3);
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge PCLK); #1;
            if (rsp_valid || PSEL) stray++;
        end
        check_eq("rst_mid_no_rsp", 32'(stray), 32'd0);

        // Normal transfer after the reset
        do_xfer("post", 1'b1, 3'd3, 8'h81, 1, 8'h00, 1'b0, 3, 2, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, maximum ACCESS cycles waited for PREADY (legal range 2..255).
REQ-002 SHALL provide port PCLK  input  1  APB clock; all logic rising-edge.
REQ-003 SHALL provide port PRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port cmd_valid  input  1  requester has a transfer pending.
REQ-005 SHALL provide port cmd_ready  output  1  bridge accepts the command this cycle.
REQ-006 SHALL provide port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL provide port cmd_addr  input  3  register address.
REQ-008 SHALL provide port cmd_wdata  input  8  write data.
REQ-009 SHALL provide port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port rsp_rdata  output  8  read data; 0 for writes and timeouts.
REQ-011 SHALL provide port rsp_err  output  1  PSLVERR or timeout on completed transfer.
REQ-012 SHALL provide port rsp_timeout  output  1  completion was a timeout abort.
REQ-013 SHALL provide ports PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-014 SHALL provide ports PADDR  output  3 and PWDATA  output  8  APB address/write data.
REQ-015 SHALL provide ports PRDATA  input  8, PREADY  input  1, PSLVERR  input  1  APB response.
REQ-016 SHALL provide port busy  output  1  high in SETUP or ACCESS.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS; PSEL=1 in SETUP and ACCESS, PENABLE=1 only in ACCESS.
REQ-018 SHALL drive cmd_ready=1 in IDLE, and in ACCESS when PREADY=1; command accepted on cmd_valid&&cmd_ready.
REQ-019 SHALL register cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA on acceptance; they stay stable through SETUP and ACCESS.
REQ-020 SHALL transition IDLE->SETUP on acceptance; SETUP->ACCESS unconditionally after exactly one cycle.
REQ-021 SHALL hold ACCESS while PREADY=0 (wait states); the transfer completes in the first ACCESS cycle sampling PREADY=1.
REQ-022 On completion SHALL go to SETUP if a new command is accepted that cycle (PSEL stays 1, PENABLE drops to 0), else IDLE.
REQ-023 SHALL assert rsp_valid for exactly one cycle, the cycle after completion, with rsp_err=registered PSLVERR and rsp_timeout=0.
REQ-024 SHALL capture PRDATA into rsp_rdata at completion of a read; rsp_rdata=0 for writes; rsp_rdata holds until next rsp_valid.
REQ-025 SHALL count ACCESS cycles with PREADY=0 in an 8-bit counter, cleared on entering ACCESS.
REQ-026 When the counter reaches TIMEOUT-1 with PREADY still 0, SHALL abort: next state IDLE, PSEL=PENABLE=0, no command accepted that cycle.
REQ-027 After an abort, SHALL pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-028 PREADY=1 in the same cycle the counter hits TIMEOUT-1 SHALL count as normal completion, not timeout.
REQ-029 SHALL ignore PRDATA, PREADY, PSLVERR outside ACCESS.
REQ-030 SHALL keep cmd_ready=0 in SETUP; cmd_valid held during SETUP/ACCESS waits without loss.
REQ-031 Back-to-back transfers SHALL take 2 cycles each with zero wait states (SETUP, ACCESS, SETUP, ...).

Reset
REQ-032 On PRESETn=0, SHALL immediately force state IDLE, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, counter to 0.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no rsp_valid pulse after release.
REQ-034 First command may be accepted in the first PCLK edge after PRESETn deasserts.

Verification
REQ-035 Write addr 3'b000 data 8'h5A, PREADY=1 in first ACCESS -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 3'b101, PREADY delayed 3 cycles, PRDATA=8'hC3 -> ACCESS lasts 4 cycles, rsp_rdata=8'hC3, rsp_err=0.
REQ-037 Write with PSLVERR=1 at PREADY -> rsp_valid, rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT=16, PREADY held 0 -> PSEL/PENABLE drop after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 Three commands cmd_valid held continuously, zero wait -> PSEL high 6 cycles continuous, PENABLE toggles 0,1,0,1,0,1, three rsp_valid pulses.
REQ-040 PRESETn pulsed low during ACCESS wait -> all outputs 0 asynchronously, no rsp_valid afterward, next command completes normally.
